// File: rtl/spi_responder_pkg.sv
// Shared Gigatron extension package: SPI responder state encoding
// and the default byte sent when nothing is queued.
package spi_responder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports: CLK, RST (sync, active-high), D (async in), lvl/rise/fall.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;
    logic [STAGES:0]   primed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync   <= {STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
            primed <= '0;
        end else begin
            sync   <= {sync[STAGES-2:0], D};
            prev   <= sync[STAGES-1];
            primed <= {primed[STAGES-1:0], 1'b1};
        end
    end

    // Edges are masked until the chain has flushed its reset value,
    // so a pin already at the other level is not seen as an edge.
    assign lvl  = sync[STAGES-1];
    assign rise = primed[STAGES] &  lvl & ~prev;
    assign fall = primed[STAGES] & ~lvl &  prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with a one-entry transmit holding register.
// Ports: CLK, RST, SCK/MOSI/nSS (async SPI), MISO/MISO_OE,
// TXDATA/TXVALID/TXREADY, RXDATA/RXVALID, TXUNDER (sticky).
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TXDATA,
    input  logic       TXVALID,
    output logic       TXREADY,
    output logic [7:0] RXDATA,
    output logic       RXVALID,
    output logic       TXUNDER
);

    logic sck_lvl_unused;
    logic sck_rise;
    logic sck_fall;
    logic nss_lvl;
    logic nss_rise;
    logic nss_fall;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sck (
        .CLK  (CLK),
        .RST  (RST),
        .D    (SCK),
        .lvl  (sck_lvl_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_nss (
        .CLK  (CLK),
        .RST  (RST),
        .D    (nSS),
        .lvl  (nss_lvl),
        .rise (nss_rise),
        .fall (nss_fall)
    );

    // MOSI goes through the same depth so it lines up with SCK.
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_lvl;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_lvl = mosi_sync[SYNC_STAGES-1];

    spi_state_t state;
    logic [2:0] bitcnt;
    logic [7:0] hold;
    logic       hold_full;
    logic       accepted;
    logic [7:0] sout;
    logic [7:0] rsh;
    logic       load;
    logic       take;

    assign take = TXVALID & ~hold_full;

    // Byte boundary: select fall in IDLE, or the SCK fall that
    // follows the eighth rise (counter already wrapped to 0).
    assign load = ((state == ST_IDLE) & nss_fall) |
                  ((state == ST_SHIFT) & ~nss_rise &
                   sck_fall & (bitcnt == 3'd0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            bitcnt    <= 3'd0;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            accepted  <= 1'b0;
            sout      <= IDLE_BYTE;
            rsh       <= 8'h00;
            RXDATA    <= 8'h00;
            RXVALID   <= 1'b0;
            TXUNDER   <= 1'b0;
        end else begin
            RXVALID <= 1'b0;

            if (take) begin
                hold      <= TXDATA;
                hold_full <= 1'b1;
                accepted  <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (nss_fall) begin
                        state  <= ST_SHIFT;
                        bitcnt <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    if (nss_rise) begin
                        state  <= ST_IDLE;
                        bitcnt <= 3'd0;
                        rsh    <= 8'h00;
                    end else if (sck_rise) begin
                        rsh    <= {rsh[6:0], mosi_lvl};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            RXDATA  <= {rsh[6:0], mosi_lvl};
                            RXVALID <= 1'b1;
                        end
                    end else if (sck_fall && bitcnt != 3'd0) begin
                        sout <= {sout[6:0], 1'b0};
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // The load sees the old holding contents even when a
            // new byte is accepted in the same cycle.
            if (load) begin
                sout <= hold_full ? hold : IDLE_BYTE;
                if (!hold_full && accepted) begin
                    TXUNDER <= 1'b1;
                end
            end
        end
    end

    assign MISO    = sout[7];
    assign MISO_OE = ~nss_lvl;
    assign TXREADY = ~hold_full;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed scenarios plus a
// long randomized transfer against a byte-level reference model.
module tb_spi_responder;

    localparam int SS     = 2;
    localparam int PH_MIN = SS + 2;
    localparam int PH     = 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       nSS = 1'b1;
    logic [7:0] TXDATA = 8'h00;
    logic       TXVALID = 1'b0;
    logic       MISO;
    logic       MISO_OE;
    logic       TXREADY;
    logic [7:0] RXDATA;
    logic       RXVALID;
    logic       TXUNDER;

    spi_responder #(
        .IDLE_BYTE   (8'hFF),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .nSS     (nSS),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .TXDATA  (TXDATA),
        .TXVALID (TXVALID),
        .TXREADY (TXREADY),
        .RXDATA  (RXDATA),
        .RXVALID (RXVALID),
        .TXUNDER (TXUNDER)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    // Reference model: one-entry holding slot, accept history,
    // sticky underflow, byte currently being shifted out.
    bit         m_full  = 0;
    bit         m_acc   = 0;
    bit         m_under = 0;
    logic [7:0] m_val   = 8'h00;
    logic [7:0] m_cur   = 8'hFF;
    int         exp_rx  = 0;

    int         rx_cnt  = 0;
    int         rx_long = 0;
    logic [7:0] rx_last = 8'h00;
    bit         rx_prev = 0;

    always @(negedge CLK) begin
        if (RXVALID === 1'b1) begin
            rx_cnt++;
            rx_last = RXDATA;
            if (rx_prev) rx_long++;
        end
        rx_prev = (RXVALID === 1'b1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed %0h expected %0h",
                     tag, obs, exp);
            $error("check %s wrong", tag);
        end
    endtask

    function automatic logic [7:0] take_byte();
        if (m_full) begin
            m_full = 0;
            return m_val;
        end
        if (m_acc) m_under = 1;
        return 8'hFF;
    endfunction

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (TXREADY !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("push_ready", 32'(TXREADY), 32'd1);
        TXVALID = 1'b1;
        TXDATA  = b;
        tick(1);
        TXVALID = 1'b0;
        m_full = 1;
        m_val  = b;
        m_acc  = 1;
        chk("push_taken", 32'(TXREADY), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_miso"},    32'(MISO),    32'd1);
        chk({tag, "_oe"},      32'(MISO_OE), 32'd0);
        chk({tag, "_txready"}, 32'(TXREADY), 32'd1);
        chk({tag, "_rxdata"},  32'(RXDATA),  32'd0);
        chk({tag, "_rxvalid"}, 32'(RXVALID), 32'd0);
        chk({tag, "_txunder"}, 32'(TXUNDER), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        tick(3);
        check_reset_outs(tag);
        RST = 1'b0;
        m_full  = 0;
        m_acc   = 0;
        m_under = 0;
        tick(6);
    endtask

    task automatic begin_xfer(input int ph);
        nSS = 1'b0;
        tick(ph + 2);
        m_cur = take_byte();
        chk("oe_on", 32'(MISO_OE), 32'd1);
    endtask

    task automatic end_xfer(input int ph);
        tick(ph);
        nSS = 1'b1;
        tick(ph + 2);
        chk("oe_off", 32'(MISO_OE), 32'd0);
    endtask

    task automatic pulses(input int n, input int ph);
        for (int k = 0; k < n; k++) begin
            MOSI = 1'($urandom);
            tick(ph);
            SCK = 1'b1;
            tick(ph);
            SCK = 1'b0;
        end
    endtask

    task automatic do_byte(input bit dopush,
                           input logic [7:0] nb,
                           input logic [7:0] mo,
                           input int ph,
                           input string tag);
        logic [7:0] mi;
        logic [7:0] exp;
        mi  = 8'h00;
        exp = m_cur;
        for (int i = 7; i >= 0; i--) begin
            MOSI = mo[i];
            tick(ph);
            mi[i] = MISO;
            SCK = 1'b1;
            if (i == 7 && dopush) push(nb);
            tick(ph);
            SCK = 1'b0;
        end
        exp_rx++;
        chk({tag, "_miso"},   32'(mi),      32'(exp));
        chk({tag, "_rxcnt"},  32'(rx_cnt),  32'(exp_rx));
        chk({tag, "_rxdata"}, 32'(rx_last), 32'(mo));
        m_cur = take_byte();
    endtask

    initial begin
        logic [7:0] r;

        do_reset("rst0");

        push(8'hA5);
        begin_xfer(PH);
        do_byte(0, 8'h00, 8'h3C, PH, "a5");
        end_xfer(PH);
        chk("a5_under", 32'(TXUNDER), 32'(m_under));

        do_reset("rst1");
        begin_xfer(PH);
        do_byte(0, 8'h00, 8'($urandom), PH, "idle");
        end_xfer(PH);
        chk("under_none", 32'(TXUNDER), 32'(m_under));
        r = 8'($urandom);
        push(r);
        begin_xfer(PH);
        do_byte(0, 8'h00, 8'($urandom), PH, "u1");
        do_byte(0, 8'h00, 8'($urandom), PH, "u2");
        end_xfer(PH);
        chk("under_set", 32'(TXUNDER), 32'(m_under));

        push(8'h01);
        begin_xfer(PH);
        do_byte(1, 8'h02, 8'($urandom), PH, "b2b1");
        do_byte(0, 8'h00, 8'($urandom), PH, "b2b2");
        end_xfer(PH);

        begin_xfer(PH);
        pulses(5, PH);
        end_xfer(PH);
        chk("partial_rxcnt", 32'(rx_cnt), 32'(exp_rx));
        r = 8'($urandom);
        push(r);
        begin_xfer(PH);
        do_byte(0, 8'h00, 8'($urandom), PH, "after_part");
        end_xfer(PH);

        begin_xfer(PH);
        pulses(3, PH);
        do_reset("rst_mid");
        pulses(8, PH);
        tick(PH);
        chk("stuck_rxcnt", 32'(rx_cnt), 32'(exp_rx));
        chk("stuck_under", 32'(TXUNDER), 32'd0);
        nSS = 1'b1;
        tick(8);
        r = 8'($urandom);
        push(r);
        begin_xfer(PH);
        do_byte(0, 8'h00, 8'($urandom), PH, "after_rst");
        end_xfer(PH);

        push(8'($urandom));
        begin_xfer(PH_MIN);
        for (int k = 0; k < 256; k++) begin
            do_byte(k < 255, 8'($urandom), 8'($urandom),
                    PH_MIN, "rand");
        end
        end_xfer(PH_MIN);
        chk("rand_under", 32'(TXUNDER), 32'(m_under));
        chk("rxvalid_width", 32'(rx_long), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
